decode_stage: RTL and testbench

Decode stage of the in-order RV32I core, sitting between instruction fetch and the immediate generator / register-file read. It accepts fetched instructions over a valid/ready handshake, classifies each opcode into the one-hot instruction formats, and flags illegal encodings. Results go through a two-entry skid buffer that drives the immediate generator's format inputs and `i_inst` directly. The stage provides full throughput with a registered upstream ready.

---
 rtl/decode_stage.sv | 70 +++++++
 tb/tb_decode_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I opcode-to-format decode behind a two-entry skid buffer with registered upstream ready
module decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_ready,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_inst,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_format_r,
  output logic                o_format_i,
  output logic                o_format_s,
  output logic                o_format_b,
  output logic                o_format_u,
  output logic                o_format_j,
  output logic                o_illegal
);
  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          fmt;
    logic                ill;
  } entry_t;
  logic [6:0] op;
  entry_t in_e, out_e, skid_e;
  logic out_v, skid_v, acc, take;
  assign op = i_inst[6:0];
  assign acc = i_valid && o_ready;
  assign take = out_v && i_ready;
  // fmt is {r, i, s, b, u, j}; illegal is simply "no format matched"
  always_comb begin
    in_e.inst = i_inst;
    in_e.pc = i_pc;
    in_e.fmt = {op == 7'h33,
                op inside {7'h67, 7'h03, 7'h13, 7'h0f, 7'h73},
                op == 7'h23,
                op == 7'h63,
                op == 7'h37 || op == 7'h17,
                op == 7'h6f};
    in_e.ill = ~|in_e.fmt;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || take) begin
      out_v <= skid_v || acc;
      skid_v <= skid_v && acc;
    end else begin
      skid_v <= skid_v || acc;
    end
  end
  // SKID data is don't-care unless skid_v, so it may load on every accept
  always_ff @(posedge i_clk) begin
    if (!out_v || take) out_e <= skid_v ? skid_e : in_e;
    if (acc) skid_e <= in_e;
  end
  assign o_ready = !skid_v;
  assign o_valid = out_v;
  assign o_inst = out_e.inst;
  assign o_pc = out_e.pc;
  assign {o_format_r, o_format_i, o_format_s, o_format_b, o_format_u, o_format_j} = out_e.fmt;
  assign o_illegal = out_e.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus handshake, flush and reset sequences for decode_stage
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n, i_valid, i_flush, i_ready;
  logic [31:0] i_inst, i_pc, o_inst, o_pc;
  logic o_ready, o_valid, fr, fi, fs, fb, fu, fj, ill;
  int pass = 0, total = 0;
  typedef struct {
    logic [31:0] inst;
    logic [5:0]  fmt;
    logic        ill;
  } vec_t;
  vec_t v[14];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
    .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_inst(o_inst), .o_pc(o_pc), .o_format_r(fr), .o_format_i(fi), .o_format_s(fs),
    .o_format_b(fb), .o_format_u(fu), .o_format_j(fj), .o_illegal(ill)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{32'h00500093, 6'b010000, 1'b0};
    v[1]  = '{32'h00112023, 6'b001000, 1'b0};
    v[2]  = '{32'hFE000EE3, 6'b000100, 1'b0};
    v[3]  = '{32'h000012B7, 6'b000010, 1'b0};
    v[4]  = '{32'h0080006F, 6'b000001, 1'b0};
    v[5]  = '{32'h002081B3, 6'b100000, 1'b0};
    v[6]  = '{32'h00000000, 6'b000000, 1'b1};
    v[7]  = '{32'hFFFFFFFF, 6'b000000, 1'b1};
    v[8]  = '{32'h00000017, 6'b000010, 1'b0};
    v[9]  = '{32'h00008067, 6'b010000, 1'b0};
    v[10] = '{32'h0000A003, 6'b010000, 1'b0};
    v[11] = '{32'h0000000F, 6'b010000, 1'b0};
    v[12] = '{32'h00000073, 6'b010000, 1'b0};
    v[13] = '{32'h00000032, 6'b000000, 1'b1};

    rst_n = 1'b0; i_valid = 1'b1; i_inst = 32'h13; i_pc = 32'h0; i_flush = 1'b0; i_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    rst_n = 1'b1; i_valid = 1'b0;
    tick;
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_ready", o_ready, 1);

    i_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      i_inst = v[i].inst;
      i_pc = 32'(i * 4);
      tick;
      chk($sformatf("v%0d_valid", i), o_valid, 1);
      chk($sformatf("v%0d_inst", i), o_inst, v[i].inst);
      chk($sformatf("v%0d_pc", i), o_pc, 64'(i * 4));
      chk($sformatf("v%0d_fmt", i), {fr, fi, fs, fb, fu, fj}, v[i].fmt);
      chk($sformatf("v%0d_ill", i), ill, v[i].ill);
      chk($sformatf("v%0d_ready", i), o_ready, 1);
    end
    i_valid = 1'b0;
    tick;
    chk("drain_valid", o_valid, 0);

    begin
      int idx = 0;
      i_inst = 32'h00000013;
      for (int c = 0; c < 20; c++) begin
        bit a, t;
        i_ready = (c >= 4);
        i_valid = (idx < 4);
        i_pc = 32'(idx * 4);
        if (c == 1) chk("bp_ready_c1", o_ready, 1);
        if (c == 2) chk("bp_ready_c2", o_ready, 0);
        if (c == 4) begin
          chk("bp_hold_valid", o_valid, 1);
          chk("bp_hold_pc", o_pc, 0);
          chk("bp_hold_ready", o_ready, 0);
        end
        a = i_valid && o_ready;
        t = o_valid && i_ready;
        if (t) got.push_back(o_pc);
        tick;
        if (a) idx++;
      end
      chk("bp_count", 64'(got.size()), 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp_order%0d", k), k < got.size() ? got[k] : 32'hDEAD, 32'(k * 4));
    end

    i_valid = 1'b0; i_ready = 1'b0;
    tick;
    i_valid = 1'b1; i_pc = 32'h100;
    tick;
    i_pc = 32'h104;
    tick;
    chk("fl_full_ready", o_ready, 0);
    i_pc = 32'h108; i_flush = 1'b1;
    tick;
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    chk("fl_valid", o_valid, 0);
    chk("fl_ready", o_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("fl_quiet%0d", k), o_valid, 0);
    end

    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h200;
    tick;
    i_pc = 32'h204; i_flush = 1'b1;
    tick;
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    chk("fl2_valid", o_valid, 0);
    chk("fl2_ready", o_ready, 1);
    tick;
    chk("fl2_drop", o_valid, 0);

    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h300;
    tick;
    i_pc = 32'h304;
    tick;
    i_valid = 1'b0;
    chk("rs_full_ready", o_ready, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rs_valid", o_valid, 0);
    chk("rs_ready", o_ready, 1);
    i_ready = 1'b1;
    tick;
    chk("rs_stale0", o_valid, 0);
    tick;
    chk("rs_stale1", o_valid, 0);

    i_valid = 1'b1; i_pc = 32'h400;
    tick;
    i_valid = 1'b0;
    chk("final_valid", o_valid, 1);
    chk("final_pc", o_pc, 32'h400);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
